// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline definitions: control-bundle layout and the EX/MEM
// occupancy state encoding.
package ex_mem_stage_pkg;

  localparam int CTRL_W      = 18;

  localparam int ALU_OP_MSB  = 17;
  localparam int ALU_OP_LSB  = 14;
  localparam int LOAD_BIT    = 13;
  localparam int STORE_BIT   = 12;
  localparam int RF_EN_BIT   = 11;
  localparam int BRANCH_BIT  = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/ex_mem_stage_entry_reg.sv
// One pipeline entry (ctrl, result, store data, dest packed flat) with a
// load enable and a synchronous clear.
module pipe_entry_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold the entry unless explicitly loaded; clear wins over load.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register implemented as a two-entry skid buffer
// (head + skid) so in_ready can be registered and never depends on
// out_ready combinationally.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = ex_mem_stage_pkg::CTRL_W,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [REG_W-1:0]  dest_out,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_enable,
  output logic [15:0]       stall_count
);

  import ex_mem_stage_pkg::*;

  localparam int ENT_W = CTRL_W + 2 * DATA_W + REG_W;

  occ_state_e state_p0, state_d;
  logic       in_ready_p0;
  logic       accept, pop;
  logic       load_head, load_skid, head_from_skid;
  logic [ENT_W-1:0] in_entry, head_d, head_p0, skid_p0;

  // Saturating increment for the stall counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept    = in_valid & in_ready_p0;
  assign pop       = out_valid & out_ready;
  assign in_entry  = {ctrl_in, alu_result_in, store_data_in, dest_in};
  assign head_d    = head_from_skid ? skid_p0 : in_entry;

  // Occupancy next-state and entry load decisions; flush empties the stage.
  always_comb begin
    state_d        = state_p0;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_p0)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (!accept && pop) begin
            state_d   = EMPTY;
          end else if (accept && pop) begin
            load_head = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_head      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register plus registered in_ready derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0    <= EMPTY;
      in_ready_p0 <= 1'b1;
    end else begin
      state_p0    <= state_d;
      in_ready_p0 <= (state_d != FULL);
    end
  end

  // Count cycles where MEM holds off a valid head; flush does not affect it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (out_valid && !out_ready) begin
      stall_count <= sat_inc16(stall_count);
    end
  end

  pipe_entry_reg #(.W(ENT_W)) u_head (
    .clk   (clk),
    .clear (reset),
    .load  (load_head),
    .d     (head_d),
    .q     (head_p0)
  );

  pipe_entry_reg #(.W(ENT_W)) u_skid (
    .clk   (clk),
    .clear (reset),
    .load  (load_skid),
    .d     (in_entry),
    .q     (skid_p0)
  );

  assign in_ready  = in_ready_p0;
  assign out_valid = (state_p0 != EMPTY);
  assign {ctrl_out, alu_result_out, store_data_out, dest_out} = head_p0;
  assign mem_read  = out_valid & ctrl_out[LOAD_BIT];
  assign mem_write = out_valid & ctrl_out[STORE_BIT];
  assign wb_enable = out_valid & ctrl_out[RF_EN_BIT];

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameters, each SHALL be given as name, default, meaning: DATA_W, 32, ALU result and store-data width; CTRL_W, 18, control bundle width; REG_W, 5, destination register index width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ctrl_in  in  CTRL_W  control bundle issued by the ID/EX register.
REQ-005 alu_result_in  in  DATA_W  EX ALU result, which is also the memory address.
REQ-006 store_data_in  in  DATA_W  forwarded rt value.
REQ-007 dest_in  in  REG_W  writeback register index.
REQ-008 in_valid  in  1  EX holds a valid instruction.
REQ-009 in_ready  out  1  stage accepts the EX instruction this cycle.
REQ-010 flush  in  1  squash all held entries (branch taken or exception).
REQ-011 out_valid  out  1  head entry valid toward MEM.
REQ-012 out_ready  in  1  MEM consumes the head this cycle.
REQ-013 ctrl_out, alu_result_out, store_data_out, dest_out  out  CTRL_W/DATA_W/DATA_W/REG_W  head entry fields.
REQ-014 mem_read, mem_write, wb_enable  out  1 each  decoded from the head ctrl; each is gated by out_valid.
REQ-015 stall_count  out  16  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Bundle decode SHALL be: ctrl[17:14] alu_op (passed through, not decoded); ctrl[13] load; ctrl[12] store; ctrl[11] rf_enable; ctrl[10] branch; ctrl[9:0] passed through.
REQ-017 Storage SHALL be two entries, head and skid, each holding ctrl, result, store data and dest.
REQ-018 The occupancy state machine SHALL have states EMPTY, ONE and FULL.
REQ-019 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-021 EMPTY: on accept, move to ONE and load the head.
REQ-022 ONE: accept without pop moves to FULL and loads the skid; pop without accept moves to EMPTY; accept with pop stays in ONE and reloads the head with the input.
REQ-023 FULL: on pop, move to ONE and move skid to head; no accept is possible in FULL.
REQ-024 out_valid SHALL be 1 exactly when state is not EMPTY.
REQ-025 Latency from accept to out_valid SHALL be 1 cycle when the stage was EMPTY.
REQ-026 Ordering SHALL be strict FIFO; no entry is duplicated or dropped except by flush.
REQ-027 flush SHALL dominate a simultaneous accept or pop: the next state is EMPTY and the input is discarded.
REQ-028 While flush=1, out_valid SHALL remain at its registered value; MEM must ignore a pop in that cycle.
REQ-029 Head and skid data SHALL load only on the transitions above; a data value held across a stall SHALL be bit-stable.
REQ-030 stall_count SHALL increment once per stall cycle, saturate at 16'hFFFF, and be unaffected by flush.
REQ-031 mem_read = out_valid & ctrl_out[13]; mem_write = out_valid & ctrl_out[12]; wb_enable = out_valid & ctrl_out[11].

Reset
REQ-032 Reset SHALL set state=EMPTY, out_valid=0, in_ready=1, stall_count=0, and all data outputs to zero.
REQ-033 Reset asserted mid-operation SHALL discard all held entries within one clock; reset SHALL take priority over flush.

Structure
REQ-034 Bundle bit positions (ALU_OP_MSB/LSB, LOAD_BIT, STORE_BIT, RF_EN_BIT, BRANCH_BIT), CTRL_W and the state encoding SHALL reside in the shared pipeline package.
REQ-035 The entry register SHALL be one sub-module, pipe_entry_reg (load enable, synchronous clear), instantiated twice.

Verification
REQ-036 Reset, then accept ctrl=18'h02800, result=32'h10, dest=5'd8 with out_ready=1 -> next cycle out_valid=1, wb_enable=1, mem_read=1, dest_out=8.
REQ-037 Accept A (result 0x1) and B (result 0x2) with out_ready=0 -> state FULL, in_ready=0; out_ready=1 for two cycles -> output 0x1 then 0x2.
REQ-038 Continuous accept with out_ready=1 for 10 cycles (results 0..9) -> outputs 0..9 with one-cycle offset, state stays ONE, stall_count=0.
REQ-039 FULL, then flush asserted with in_valid=1 and out_ready=1 -> next cycle out_valid=0, state EMPTY, the flushed input never appears at the output.
REQ-040 Hold out_ready=0 with the stage occupied for 70000 cycles -> stall_count=16'hFFFF; head data unchanged throughout.
REQ-041 Assert reset while FULL with flush=1 -> next cycle out_valid=0, in_ready=1, stall_count=0.
